// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the FIFO drain DMA engine
package dma_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_XFER = 2'd1,
        DMA_DONE = 2'd2
    } dma_drain_state_t;

    localparam int DMA_SKID_DEPTH = 2;

endpackage

// File: rtl/dma_fifo_drain_if.sv
// rtl/dma_fifo_drain_if.sv - FIFO read channel and memory write channel of the drain engine
interface dma_fifo_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  fifo_empty;
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  mem_wr_valid;
    logic                  mem_wr_ready;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    modport master (
        input  fifo_empty, fifo_rdata, mem_wr_ready,
        output fifo_r_en, mem_wr_valid, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output fifo_empty, fifo_rdata, mem_wr_ready,
        input  fifo_r_en, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/dma_skid_buf.sv
// rtl/dma_skid_buf.sv - 2-entry skid buffer between FIFO read data and memory write port
module dma_skid_buf
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            occ_o
);
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]            occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_d = push_data_i;
                    else               ent1_d = push_data_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (occ_q == 2'(DMA_SKID_DEPTH)) begin
                        ent0_d = ent1_q;
                        ent1_d = push_data_i;
                    end else begin
                        ent0_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = ent0_q;
    assign occ_o  = occ_q;
endmodule

// File: rtl/dma_fifo_drain.sv
// rtl/dma_fifo_drain.sv - DMA engine draining the staging FIFO into word writes to memory
module dma_fifo_drain
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    dma_fifo_drain_if.master      bus
);
    dma_drain_state_t      state_q, state_d;
    logic [LEN_WIDTH-1:0]  pops_left_q, pops_left_d;
    logic [LEN_WIDTH-1:0]  writes_left_q, writes_left_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  aborted_q, aborted_d;
    logic                  inflight_q;

    logic                  xfer_abort;
    logic                  accept;
    logic                  pop;
    logic [1:0]            occ;
    logic [2:0]            fill;
    logic [DATA_WIDTH-1:0] head;

    assign xfer_abort = (state_q == DMA_XFER) && abort;
    assign accept     = bus.mem_wr_valid && bus.mem_wr_ready;
    // Words the buffer will hold after this edge if nothing new is popped.
    assign fill       = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, accept};
    assign pop        = (state_q == DMA_XFER) && !xfer_abort && !bus.fifo_empty
                        && (pops_left_q != '0) && (fill < 3'(DMA_SKID_DEPTH));

    dma_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (bus.fifo_rdata),
        .pop_i       (accept),
        .flush_i     (xfer_abort),
        .head_o      (head),
        .occ_o       (occ)
    );

    always_comb begin
        state_d       = state_q;
        pops_left_d   = pops_left_q;
        writes_left_d = writes_left_q;
        addr_d        = addr_q;
        aborted_d     = aborted_q;
        case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    addr_d        = dst_addr;
                    pops_left_d   = xfer_len;
                    writes_left_d = xfer_len;
                    aborted_d     = 1'b0;
                    state_d       = (xfer_len == '0) ? DMA_DONE : DMA_XFER;
                end
            end
            DMA_XFER: begin
                if (pop) pops_left_d = pops_left_q - LEN_WIDTH'(1);
                if (accept) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (writes_left_q != '0) writes_left_d = writes_left_q - LEN_WIDTH'(1);
                end
                if (xfer_abort) begin
                    state_d   = DMA_IDLE;
                    aborted_d = 1'b1;
                end else if (accept && (writes_left_q == LEN_WIDTH'(1))) begin
                    state_d = DMA_DONE;
                end
            end
            DMA_DONE: state_d = DMA_IDLE;
            default:  state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= DMA_IDLE;
            pops_left_q   <= '0;
            writes_left_q <= '0;
            addr_q        <= '0;
            aborted_q     <= 1'b0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pops_left_q   <= pops_left_d;
            writes_left_q <= writes_left_d;
            addr_q        <= addr_d;
            aborted_q     <= aborted_d;
            inflight_q    <= pop;
        end
    end

    assign busy             = (state_q != DMA_IDLE);
    assign done             = (state_q == DMA_DONE);
    assign aborted          = aborted_q;
    assign bus.fifo_r_en    = pop;
    assign bus.mem_wr_valid = (occ != 2'd0);
    assign bus.mem_wr_addr  = addr_q;
    assign bus.mem_wr_data  = head;
endmodule
